// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg
// Shared types and constants for the frame receive controller.
//   rx_state_t        : controller state encoding
//   SYNC_BYTE_DEFAULT : default frame start marker
//   DROP_MAX          : saturation value of the drop counter
package rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    HOLD
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] DROP_MAX          = 8'hFF;

endpackage

// File: rtl/rx_payload_buf.sv
// rx_payload_buf
// Payload storage for one frame: DEPTH x 8 register array, one synchronous
// write port and one registered read port.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  : write strobe, address, data
//   raddr           : read address
//   rdata           : registered read data, mem[raddr] one cycle later
module rx_payload_buf #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  // Array is rounded up to a power of two so any AW-bit index is legal;
  // entries at or above DEPTH are never written.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem [0:(1 << AW) - 1];

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (we && (waddr < 8'(DEPTH))) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  // Out-of-range reads return 0 rather than a stale word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
    end else if (raddr < 8'(DEPTH)) begin
      rdata <= mem[raddr[AW-1:0]];
    end else begin
      rdata <= 8'h00;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl
// Sequences the byte receiver's byte/strobe stream into framed packets
// (sync, length, payload, optional checksum), stores the payload, and offers
// a completed frame through a valid/ack handshake.
// Build option: define RX_FRAME_CHECKSUM_EN to add the trailing checksum byte
// and the err_csum report; without it a frame ends after its last payload byte.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx_enable    : allow reception; dropping it mid-frame aborts silently
//   byte_in      : received byte, qualified by byte_valid
//   byte_valid   : single-cycle byte strobe
//   frame_valid  : a complete frame is held
//   frame_ack    : consumer releases the held frame
//   frame_len    : payload length of the held frame
//   rd_addr      : payload read index
//   rd_data      : payload byte at rd_addr, one cycle later
//   err_len      : one-cycle pulse, illegal length byte
//   err_csum     : one-cycle pulse, checksum mismatch
//   err_timeout  : one-cycle pulse, inter-byte timeout
//   drop_cnt     : saturating count of bytes dropped while a frame is held
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_enable,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       frame_valid,
  input  logic       frame_ack,
  output logic [7:0] frame_len,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       err_len,
  output logic       err_csum,
  output logic       err_timeout,
  output logic [7:0] drop_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  rx_state_t state, state_nxt;

  logic [7:0]    len_q, len_nxt;
  logic [7:0]    idx_q, idx_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [7:0]    drop_nxt;
  logic          tmo_expire;
  logic          err_len_nxt, err_timeout_nxt;
  logic          buf_we;
`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0]    csum_q, csum_nxt, csum_sum;
  logic          err_csum_nxt;
`endif

  rx_payload_buf #(
    .DEPTH(MAX_LEN)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (buf_we && !rst),
    .waddr(idx_q),
    .wdata(byte_in),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // Next-state logic. Inside a frame, priority is: rx_enable abort, then a
  // byte (which beats a same-cycle timeout), then timeout expiry. The timeout
  // counter defaults to 0, so it clears on every byte and every state change.
  always_comb begin
    state_nxt       = state;
    len_nxt         = len_q;
    idx_nxt         = idx_q;
    tmo_nxt         = '0;
    drop_nxt        = drop_cnt;
    err_len_nxt     = 1'b0;
    err_timeout_nxt = 1'b0;
    buf_we          = 1'b0;
    tmo_expire      = !byte_valid && (tmo_cnt == TW'(TIMEOUT - 1));
`ifdef RX_FRAME_CHECKSUM_EN
    csum_nxt        = csum_q;
    err_csum_nxt    = 1'b0;
    csum_sum        = csum_q + byte_in;
`endif

    case (state)
      IDLE: begin
        if (byte_valid && rx_enable && (byte_in == SYNC_BYTE)) begin
          state_nxt = LEN;
        end
      end

      LEN: begin
        if (!rx_enable) begin
          state_nxt = IDLE;
        end else if (byte_valid) begin
          if ((byte_in == 8'h00) || (byte_in > 8'(MAX_LEN))) begin
            err_len_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            len_nxt   = byte_in;
            idx_nxt   = 8'h00;
`ifdef RX_FRAME_CHECKSUM_EN
            csum_nxt  = byte_in;
`endif
            state_nxt = PAYLOAD;
          end
        end else if (tmo_expire) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end

      PAYLOAD: begin
        if (!rx_enable) begin
          state_nxt = IDLE;
        end else if (byte_valid) begin
          buf_we  = 1'b1;
          idx_nxt = idx_q + 8'd1;
`ifdef RX_FRAME_CHECKSUM_EN
          csum_nxt = csum_sum;
          if (idx_q == len_q - 8'd1) begin
            state_nxt = CSUM;
          end
`else
          if (idx_q == len_q - 8'd1) begin
            state_nxt = HOLD;
          end
`endif
        end else if (tmo_expire) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end

`ifdef RX_FRAME_CHECKSUM_EN
      // Length + payload + checksum byte must sum to zero mod 256.
      CSUM: begin
        if (!rx_enable) begin
          state_nxt = IDLE;
        end else if (byte_valid) begin
          if (csum_sum == 8'h00) begin
            state_nxt = HOLD;
          end else begin
            err_csum_nxt = 1'b1;
            state_nxt    = IDLE;
          end
        end else if (tmo_expire) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
`endif

      // A byte arriving with the ack is still counted as dropped.
      HOLD: begin
        if (byte_valid && (drop_cnt != DROP_MAX)) begin
          drop_nxt = drop_cnt + 8'd1;
        end
        if (frame_ack) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // frame_valid and frame_len are loaded from the next state so they line up
  // with the state register instead of lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= 8'h00;
      idx_q       <= 8'h00;
      tmo_cnt     <= '0;
      drop_cnt    <= 8'h00;
      frame_valid <= 1'b0;
      frame_len   <= 8'h00;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      len_q       <= len_nxt;
      idx_q       <= idx_nxt;
      tmo_cnt     <= tmo_nxt;
      drop_cnt    <= drop_nxt;
      frame_valid <= (state_nxt == HOLD);
      if ((state_nxt == HOLD) && (state != HOLD)) begin
        frame_len <= len_q;
      end
      err_len     <= err_len_nxt;
      err_timeout <= err_timeout_nxt;
    end
  end

`ifdef RX_FRAME_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q   <= 8'h00;
      err_csum <= 1'b0;
    end else begin
      csum_q   <= csum_nxt;
      err_csum <= err_csum_nxt;
    end
  end
`else
  assign err_csum = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl
// Self-checking bench for rx_frame_ctrl. A frame-level model (byte queue per
// frame, checksum as a plain sum) predicts every registered output each cycle;
// directed sequences add hand-computed literal checks. Adapts to whether
// RX_FRAME_CHECKSUM_EN is defined.
module tb_rx_frame_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 255;
  localparam logic [7:0] SYNC    = 8'hA5;
`ifdef RX_FRAME_CHECKSUM_EN
  localparam int CSUM_EN = 1;
`else
  localparam int CSUM_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_enable;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       frame_valid;
  logic       frame_ack;
  logic [7:0] frame_len;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       err_len;
  logic       err_csum;
  logic       err_timeout;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_frame_ctrl #(
    .MAX_LEN  (MAX_LEN),
    .TIMEOUT  (TIMEOUT),
    .SYNC_BYTE(SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_enable  (rx_enable),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .frame_len  (frame_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .err_len    (err_len),
    .err_csum   (err_csum),
    .err_timeout(err_timeout),
    .drop_cnt   (drop_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // fq holds the bytes of the frame in progress (sync first); empty = hunting.
  logic [7:0] fq[$];
  logic [7:0] mbuf    [MAX_LEN];
  bit         written [MAX_LEN];
  bit         held, live;
  int         idle_run, n, sum, ra;
  logic [7:0] m_drop, m_len, m_rd;
  bit         m_valid, m_elen, m_ecsum, m_etmo, m_rd_known;

  initial live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      held = 0; idle_run = 0;
      m_drop = 0; m_len = 0; m_rd = 0; m_rd_known = 1;
      m_valid = 0; m_elen = 0; m_ecsum = 0; m_etmo = 0;
      for (int i = 0; i < MAX_LEN; i++) written[i] = 0;
      live = 1;
    end else begin
      m_elen = 0; m_ecsum = 0; m_etmo = 0;
      ra = int'(rd_addr);
      m_rd_known = (ra < MAX_LEN) && written[ra % MAX_LEN];
      if (m_rd_known) m_rd = mbuf[ra];
      if (held) begin
        if (byte_valid && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        if (frame_ack) held = 0;
      end else if (fq.size() == 0) begin
        if (byte_valid && rx_enable && byte_in == SYNC) fq.push_back(byte_in);
        idle_run = 0;
      end else if (!rx_enable) begin
        fq.delete();
        idle_run = 0;
      end else if (byte_valid) begin
        idle_run = 0;
        fq.push_back(byte_in);
        n = int'(fq[1]);
        if (fq.size() == 2) begin
          if (n == 0 || n > MAX_LEN) begin
            m_elen = 1;
            fq.delete();
          end
        end else begin
          if (fq.size() <= n + 2) begin
            mbuf[fq.size() - 3]    = byte_in;
            written[fq.size() - 3] = 1;
          end
          if (fq.size() == n + 2 + CSUM_EN) begin
            sum = 0;
            for (int i = 1; i < fq.size(); i++) sum += int'(fq[i]);
            if (CSUM_EN == 0 || sum % 256 == 0) begin
              held  = 1;
              m_len = 8'(n);
            end else begin
              m_ecsum = 1;
            end
            fq.delete();
          end
        end
      end else begin
        idle_run++;
        if (idle_run == TIMEOUT) begin
          m_etmo = 1;
          fq.delete();
          idle_run = 0;
        end
      end
      m_valid = held;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      checkOutput("frame_valid", 32'(frame_valid), 32'(m_valid));
      checkOutput("err_len", 32'(err_len), 32'(m_elen));
      checkOutput("err_csum", 32'(err_csum), 32'(m_ecsum));
      checkOutput("err_timeout", 32'(err_timeout), 32'(m_etmo));
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (m_valid) checkOutput("frame_len", 32'(frame_len), 32'(m_len));
      if (m_rd_known) checkOutput("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] seq [8], input int cnt);
    for (int i = 0; i < cnt; i++) drive_byte(seq[i]);
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic read_check(input logic [7:0] addr, input logic [7:0] exp, input string name);
    @(negedge clk);
    byte_valid = 1'b0;
    rd_addr    = addr;
    @(negedge clk);
    checkOutput(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic ack_frame();
    @(negedge clk);
    byte_valid = 1'b0;
    frame_ack  = 1'b1;
    @(negedge clk);
    frame_ack  = 1'b0;
    checkOutput("ack_valid_low", 32'(frame_valid), 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
    checkOutput({tag, "_frame_len"}, 32'(frame_len), 32'h0);
    checkOutput({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    checkOutput({tag, "_drop_cnt"}, 32'(drop_cnt), 32'h0);
    checkOutput({tag, "_errs"}, {29'h0, err_len, err_csum, err_timeout}, 32'h0);
  endtask

  task automatic send_good3();
    applyStimulus('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97, 8'h00, 8'h00}, 5 + CSUM_EN);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  k;
    bit  seen;
    rst = 1'b1; rx_enable = 1'b1; byte_in = 8'h00; byte_valid = 1'b0;
    frame_ack = 1'b0; rd_addr = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Good frame
    send_good3();
    idle(1);
    checkOutput("good_valid", 32'(frame_valid), 32'h1);
    checkOutput("good_len", 32'(frame_len), 32'h3);
    read_check(8'd0, 8'h11, "good_rd0");
    read_check(8'd1, 8'h22, "good_rd1");
    read_check(8'd2, 8'h33, "good_rd2");
    ack_frame();

`ifdef RX_FRAME_CHECKSUM_EN
    // Bad checksum, then a good frame straight after
    applyStimulus('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98, 8'h00, 8'h00}, 6);
    idle(1);
    checkOutput("badcsum_err", 32'(err_csum), 32'h1);
    checkOutput("badcsum_valid", 32'(frame_valid), 32'h0);
    send_good3();
    idle(1);
    checkOutput("badcsum_err_gone", 32'(err_csum), 32'h0);
    checkOutput("after_bad_valid", 32'(frame_valid), 32'h1);
    ack_frame();
`endif

    // Illegal lengths
    applyStimulus('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    idle(1);
    checkOutput("len0_err", 32'(err_len), 32'h1);
    applyStimulus('{8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    idle(1);
    checkOutput("len17_err", 32'(err_len), 32'h1);
    applyStimulus('{8'hA5, 8'h01, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}, 3 + CSUM_EN);
    idle(1);
    checkOutput("len1_valid", 32'(frame_valid), 32'h1);
    checkOutput("len1_len", 32'(frame_len), 32'h1);
    read_check(8'd0, 8'h5A, "len1_rd0");
    ack_frame();

    // Timeout after silence: err_timeout seen 256 cycles after the last strobe
    applyStimulus('{8'hA5, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    k = 0; seen = 0;
    while (!seen && k < 400) begin
      @(negedge clk);
      byte_valid = 1'b0;
      k++;
      seen = err_timeout;
    end
    checkOutput("tmo_latency", seen ? 32'(k) : 32'h0, 32'd256);

    // Byte lands exactly on the expiry cycle: no timeout, frame completes
    applyStimulus('{8'hA5, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    idle(254);
    drive_byte(8'h22);
`ifdef RX_FRAME_CHECKSUM_EN
    drive_byte(8'hCB);
`endif
    idle(1);
    checkOutput("tmo_edge_no_err", 32'(err_timeout), 32'h0);
    checkOutput("tmo_edge_valid", 32'(frame_valid), 32'h1);
    checkOutput("tmo_edge_len", 32'(frame_len), 32'h2);
    ack_frame();

    // rx_enable abort mid-payload, then a frame carrying sync-valued data
    applyStimulus('{8'hA5, 8'h03, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    @(negedge clk);
    byte_valid = 1'b0;
    rx_enable  = 1'b0;
    @(negedge clk);
    rx_enable  = 1'b1;
    idle(2);
    checkOutput("abort_no_err", {29'h0, err_len, err_csum, err_timeout}, 32'h0);
    applyStimulus('{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'hB4, 8'h00, 8'h00, 8'h00}, 4 + CSUM_EN);
    idle(1);
    checkOutput("syncdata_valid", 32'(frame_valid), 32'h1);
    read_check(8'd1, 8'hA5, "syncdata_rd1");
    ack_frame();

    // Overrun while held
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_good3();
    idle(1);
    applyStimulus('{8'h01, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    idle(1);
    checkOutput("drop3", 32'(drop_cnt), 32'd3);
    checkOutput("drop3_still_valid", 32'(frame_valid), 32'h1);
    for (int i = 0; i < 300; i++) drive_byte(8'(i));
    idle(1);
    checkOutput("drop_sat", 32'(drop_cnt), 32'd255);
    ack_frame();

    // Reset mid-payload
    applyStimulus('{8'hA5, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    @(negedge clk);
    byte_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    check_reset_values("midrst");
    send_good3();
    idle(1);
    checkOutput("midrst_valid", 32'(frame_valid), 32'h1);
    checkOutput("midrst_len", 32'(frame_len), 32'h3);

    // Ack and byte together in HOLD: byte counted, frame released
    @(negedge clk);
    byte_in    = 8'h77;
    byte_valid = 1'b1;
    frame_ack  = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    frame_ack  = 1'b0;
    checkOutput("ackbyte_drop", 32'(drop_cnt), 32'd1);
    checkOutput("ackbyte_valid", 32'(frame_valid), 32'h0);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
